// File: rtl/act_pool_writer_pkg.sv
// rtl/act_pool_writer_pkg.sv - shared types, constants and helpers for act_pool_writer
package act_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

    localparam int POOL_BEATS = 4;
    localparam int LANES      = 4;

    function automatic logic [7:0] relu8(input logic [7:0] x);
        return x[7] ? 8'd0 : x;
    endfunction

    // Byte enables for a partial word holding n filled lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] n);
        case (n)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/act_pool_writer_if.sv
// rtl/act_pool_writer_if.sv - conv result stream and output SRAM write bus
interface act_conv_if #(parameter int DATA_W = 8);
    logic              conv_valid;
    logic [DATA_W-1:0] conv_result;
    logic              last;

    modport master (output conv_valid, conv_result, last);
    modport slave  (input  conv_valid, conv_result, last);
endinterface

interface act_wr_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [4*DATA_W-1:0] wr_data;
    logic [3:0]          wr_strb;

    modport master (output wr_en, wr_addr, wr_data, wr_strb);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_strb);
endinterface

// File: rtl/act_pool_writer_byte_packer.sv
// rtl/act_pool_writer_byte_packer.sv - packs bytes into 4-lane words, flushes partial words
module byte_packer
    import act_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                byte_valid_i,
    input  logic [DATA_W-1:0]   byte_i,
    input  logic                flush_req_i,
    output logic                fire_o,
    output logic                wr_en_o,
    output logic [4*DATA_W-1:0] wr_data_o,
    output logic [3:0]          wr_strb_o
);

    logic [1:0]          lane_q, lane_d;
    logic [4*DATA_W-1:0] word_q, word_d, data_d;
    logic [3:0]          strb_d;
    logic                en_d;

    // word_q is cleared after every write so unfilled lanes of a flush word read as zero.
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        en_d   = 1'b0;
        data_d = '0;
        strb_d = '0;
        if (flush_req_i) begin
            if (lane_q != 2'd0) begin
                en_d   = 1'b1;
                data_d = word_q;
                strb_d = lane_mask(lane_q);
            end
            lane_d = 2'd0;
            word_d = '0;
        end else if (byte_valid_i) begin
            if (lane_q == 2'(LANES-1)) begin
                en_d   = 1'b1;
                data_d = {byte_i, word_q[3*DATA_W-1:0]};
                strb_d = 4'hF;
                lane_d = 2'd0;
                word_d = '0;
            end else begin
                word_d[int'(lane_q)*DATA_W +: DATA_W] = byte_i;
                lane_d = lane_q + 2'd1;
            end
        end
        fire_o = en_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q    <= 2'd0;
            word_q    <= '0;
            wr_en_o   <= 1'b0;
            wr_data_o <= '0;
            wr_strb_o <= 4'd0;
        end else begin
            lane_q    <= lane_d;
            word_q    <= word_d;
            wr_en_o   <= en_d;
            wr_data_o <= data_d;
            wr_strb_o <= strb_d;
        end
    end

endmodule

// File: rtl/act_pool_writer.sv
// rtl/act_pool_writer.sv - ReLU, optional 2x2 max-pool and packed SRAM writer for one column
module act_pool_writer
    import act_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pool_en_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    act_conv_if.slave         conv,
    act_wr_if.master          wr,
    output logic              done_o,
    output logic              err_o
);

    state_e            state_q, state_d;
    logic              pool_q;
    logic [ADDR_W-1:0] addr_q, wr_addr_q;
    logic [1:0]        beat_q;
    logic [DATA_W-1:0] max_q, relu, win_max, pk_byte;
    logic              err_q;
    logic              accept, flush_req, pool_mode, byte_valid, fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (conv.conv_valid) state_d = conv.last ? S_FLUSH : S_RUN;
            S_RUN:   if (conv.conv_valid && conv.last) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = conv.conv_valid && (state_q == S_IDLE || state_q == S_RUN);
        flush_req = (state_q == S_FLUSH);
        done_o    = (state_q == S_DONE);
    end

    // The first beat of a frame is processed in IDLE, before pool_q holds the new mode.
    always_comb begin
        relu       = relu8(conv.conv_result);
        pool_mode  = (state_q == S_IDLE) ? pool_en_i : pool_q;
        win_max    = (beat_q == 2'd0 || relu > max_q) ? relu : max_q;
        byte_valid = accept && (!pool_mode || conv.last || beat_q == 2'(POOL_BEATS-1));
        pk_byte    = pool_mode ? win_max : relu;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pool_q    <= 1'b0;
            addr_q    <= '0;
            wr_addr_q <= '0;
            beat_q    <= 2'd0;
            max_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == S_DONE) begin
                beat_q <= 2'd0;
                max_q  <= '0;
            end else if (accept && pool_mode) begin
                beat_q <= conv.last ? 2'd0 : beat_q + 2'd1;
                max_q  <= win_max;
            end

            if (state_q == S_IDLE && conv.conv_valid) begin
                pool_q <= pool_en_i;
                addr_q <= base_addr_i;
            end else if (fire) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (fire) wr_addr_q <= addr_q;

            // Frame start clears the sticky error; a misaligned pool last or a dropped beat sets it.
            if (state_q == S_IDLE && conv.conv_valid)
                err_q <= pool_en_i && conv.last;
            else if (accept && pool_q && conv.last && beat_q != 2'(POOL_BEATS-1))
                err_q <= 1'b1;
            else if (conv.conv_valid && !accept)
                err_q <= 1'b1;
        end
    end

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk         (clk),
        .rst         (rst),
        .byte_valid_i(byte_valid),
        .byte_i      (pk_byte),
        .flush_req_i (flush_req),
        .fire_o      (fire),
        .wr_en_o     (wr.wr_en),
        .wr_data_o   (wr.wr_data),
        .wr_strb_o   (wr.wr_strb)
    );

    assign wr.wr_addr = wr_addr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_act_pool_writer.sv
// tb/tb_act_pool_writer.sv - scoreboard bench for act_pool_writer
module tb_act_pool_writer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic pool_en;
    logic [ADDR_W-1:0] base;
    logic done, err;

    act_conv_if #(.DATA_W(DATA_W)) cv ();
    act_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

    act_pool_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pool_en_i  (pool_en),
        .base_addr_i(base),
        .conv       (cv),
        .wr         (wb),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] beats[$];
    int checks = 0, errors = 0;
    int exp_done = 0, done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: ReLU every beat, take the max of each group of four (the last group may be
    // short) in pool mode, then cut the byte list into 4-byte words at consecutive addresses.
    function automatic bit model_frame(input bit pool, input logic [7:0] b);
        int  outb[$];
        int  vals[$];
        int  m;
        wr_t w;
        foreach (beats[i]) vals.push_back($signed(beats[i]) < 0 ? 0 : int'(beats[i]));
        if (!pool) outb = vals;
        else begin
            for (int g = 0; g < vals.size(); g += 4) begin
                m = 0;
                for (int j = g; j < g + 4 && j < vals.size(); j++) if (vals[j] > m) m = vals[j];
                outb.push_back(m);
            end
        end
        for (int k = 0; k < outb.size(); k += 4) begin
            w.addr = b + 8'(k / 4);
            w.data = 32'd0;
            w.strb = 4'd0;
            for (int j = 0; j < 4 && k + j < outb.size(); j++) begin
                w.data = w.data | (32'(outb[k+j]) << (8 * j));
                w.strb[j] = 1'b1;
            end
            exp_q.push_back(w);
        end
        return pool && (vals.size() % 4 != 0);
    endfunction

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (wb.wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                             wb.wr_addr, wb.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wb.wr_addr), 32'(e.addr));
                    check("wr_data", wb.wr_data, e.data);
                    check("wr_strb", 32'(wb.wr_strb), 32'(e.strb));
                end
            end
            if (done) done_seen++;
        end
    end

    task automatic run_frame(input bit p, input logic [7:0] b, input bit drop);
        bit e;
        int n;
        n = beats.size();
        e = model_frame(p, b);
        exp_done++;
        for (int i = 0; i < n; i++) begin
            pool_en        = p;
            base           = b;
            cv.conv_valid  = 1'b1;
            cv.conv_result = beats[i];
            cv.last        = (i == n - 1);
            @(posedge clk); #1;
            if (i == 0) check("err_after_first_beat", 32'(err), 32'(p && n == 1));
            pool_en = 1'($urandom);
            base    = 8'($urandom);
        end
        cv.last        = 1'b0;
        cv.conv_valid  = drop;
        cv.conv_result = 8'h55;
        @(negedge clk);
        check("done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        cv.conv_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("err_end", 32'(err), 32'(e | drop));
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        cv.conv_valid  = 1'b0;
        cv.conv_result = '0;
        cv.last        = 1'b0;
        pool_en        = 1'b0;
        base           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wb.wr_en), 32'd0);
        check("rst_wr_addr", 32'(wb.wr_addr), 32'd0);
        check("rst_wr_data", wb.wr_data, 32'd0);
        check("rst_wr_strb", 32'(wb.wr_strb), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        beats = '{8'd5, 8'hFD, 8'd127, 8'h80, 8'd9, 8'd1, 8'd2, 8'd3};
        run_frame(1'b0, 8'h10, 1'b0);
        beats = '{8'd1, 8'd9, 8'hFC, 8'd3, 8'hFF, 8'hFE, 8'hF9, 8'hFB};
        run_frame(1'b1, 8'h00, 1'b0);
        beats = '{8'd2, 8'd7, 8'd1, 8'd0, 8'd4, 8'd6};
        run_frame(1'b1, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        beats = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        run_frame(1'b0, 8'hFF, 1'b0);

        beats.delete();
        repeat (4) beats.push_back(8'($urandom));
        run_frame(1'b0, 8'($urandom), 1'b1);

        pool_en = 1'b1;
        base    = 8'h40;
        for (int i = 0; i < 3; i++) begin
            cv.conv_valid  = 1'b1;
            cv.conv_result = 8'($urandom_range(1, 127));
            cv.last        = 1'b0;
            @(posedge clk); #1;
        end
        cv.conv_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_wr_en", 32'(wb.wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wb.wr_addr), 32'd0);
        check("midrst_wr_data", wb.wr_data, 32'd0);
        check("midrst_wr_strb", 32'(wb.wr_strb), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beats = '{8'd3, 8'd3, 8'd3, 8'd3};
        run_frame(1'b1, 8'h20, 1'b0);

        for (int f = 0; f < 24; f++) begin
            beats.delete();
            repeat ($urandom_range(1, 13)) beats.push_back(8'($urandom));
            run_frame(f[0], 8'($urandom), 1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(exp_done));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
